// File: rtl/bch_pkg.sv
// Shared constants and FSM state type for the BCH(63,24) systematic encoder path.
package bch_pkg;

  localparam int BCH_N = 63;
  localparam int BCH_K = 24;
  localparam int BCH_P = BCH_N - BCH_K;

  // Generator polynomial coefficients, bit i = g_i (g_0 and g_39 are both 1)
  localparam logic [BCH_P:0] G_POLY = 40'hF69AC20921;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MSG, PAR} bch_enc_state_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// Division LFSR for the BCH parity: absorbs message bits, then shifts the remainder out MSB-first.
// Advances one bit per shift_en; clr dominates shift_en.
module bch_parity_lfsr
  import bch_pkg::*;
#(
  parameter int P = BCH_P
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_en,
  input  logic par_mode,
  input  logic din,
  output logic par_msb
);

  logic [P-1:0] lfsr;
  logic [P-1:0] lfsr_nxt;
  logic         fb;

  // In parity mode feedback is forced to zero so the register becomes a plain shifter
  always_comb begin
    fb          = par_mode ? 1'b0 : (din ^ lfsr[P-1]);
    lfsr_nxt    = '0;
    lfsr_nxt[0] = fb;
    for (int i = 1; i < P; i++) begin
      lfsr_nxt[i] = lfsr[i-1] ^ (G_POLY[i] & fb);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (clr) begin
      lfsr <= '0;
    end else if (shift_en) begin
      lfsr <= lfsr_nxt;
    end
  end

  assign par_msb = lfsr[P-1];

endmodule

// File: rtl/bch_enc_frame_ctrl.sv
// Frame sequencer for the BCH(63,24) encoder: one K-bit word in, N serial codeword bits out.
// Stalls on cw_ready; next frame starts without a bubble. Optional frame_cnt via BCH_FRAME_CNT_EN.
module bch_enc_frame_ctrl
  import bch_pkg::*;
#(
  parameter int N = BCH_N,
  parameter int K = BCH_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic         cw_bit,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic         cw_sof,
  output logic         cw_eof,
  output logic         busy
`ifdef BCH_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  localparam int P = N - K;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P - 1);

  bch_enc_state_t   state;
  bch_enc_state_t   state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [K-1:0]     shreg;
  logic             par_msb;
  logic             last_msg;
  logic             last_par;
  logic             accept;
  logic             beat;

  assign last_msg = (bit_cnt == K_LAST);
  assign last_par = (bit_cnt == P_LAST);
  assign accept   = msg_valid & msg_ready;
  assign beat     = cw_valid & cw_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // msg_ready in PAR depends on cw_ready so a new frame can follow the eof beat directly
  always_comb begin
    state_nxt = state;
    msg_ready = 1'b0;
    cw_valid  = 1'b0;
    cw_bit    = 1'b0;
    cw_sof    = 1'b0;
    cw_eof    = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_nxt = MSG;
      end
      MSG: begin
        cw_valid = 1'b1;
        cw_bit   = shreg[K-1];
        cw_sof   = (bit_cnt == '0);
        if (cw_ready && last_msg) state_nxt = PAR;
      end
      PAR: begin
        cw_valid  = 1'b1;
        cw_bit    = par_msb;
        cw_eof    = last_par;
        msg_ready = last_par & cw_ready;
        if (cw_ready && last_par) state_nxt = msg_valid ? MSG : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
    end else if (beat) begin
      if ((state == MSG && last_msg) || (state == PAR && last_par)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= cnt_inc(bit_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= msg_data;
    end else if (beat && state == MSG) begin
      shreg <= {shreg[K-2:0], 1'b0};
    end
  end

  bch_parity_lfsr #(
    .P(P)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .shift_en (beat),
    .par_mode (state == PAR),
    .din      (shreg[K-1]),
    .par_msb  (par_msb)
  );

`ifdef BCH_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (beat && cw_eof) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bch_enc_frame_ctrl.sv
// Directed bench for bch_enc_frame_ctrl; expected codewords come from a polynomial long-division model.
module tb_bch_enc_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic [23:0] msg_data;
  logic        msg_valid;
  logic        msg_ready;
  logic        cw_bit;
  logic        cw_valid;
  logic        cw_ready;
  logic        cw_sof;
  logic        cw_eof;
  logic        busy;
`ifdef BCH_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] G_REF   = 40'hF69AC20921;
  localparam logic [62:0] SOF_EXP = {1'b1, 62'b0};
  localparam logic [62:0] EOF_EXP = 63'd1;

  bch_enc_frame_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_data  (msg_data),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .cw_bit    (cw_bit),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_sof    (cw_sof),
    .cw_eof    (cw_eof),
    .busy      (busy)
`ifdef BCH_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [62:0] exp_cw(input logic [23:0] m);
    logic [62:0] r;
    r = {m, 39'b0};
    for (int i = 62; i >= 39; i--) begin
      if (r[i]) r[i-39 +: 40] = r[i-39 +: 40] ^ G_REF;
    end
    return {m, r[38:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; collects one codeword in transmission order.
  task automatic frame(input logic [23:0] m, input bit stall,
                       output logic [62:0] cw, output logic [62:0] sofv,
                       output logic [62:0] eofv, output int bad, output int cyc);
    int   idx;
    logic pb, ps, pe, pstall, rdy;
    cw = '0; sofv = '0; eofv = '0; bad = 0; cyc = 0; idx = 0;
    pstall = 1'b0; pb = 1'b0; ps = 1'b0; pe = 1'b0;
    msg_data = m; msg_valid = 1'b1; cw_ready = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    while (idx < 63 && cyc < 1000) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cw_ready = rdy;
      #1;
      if (cw_valid !== 1'b1) bad++;
      if (pstall && (cw_bit !== pb || cw_sof !== ps || cw_eof !== pe)) bad++;
      if (msg_ready !== ((idx == 62) && rdy)) bad++;
      if (rdy) begin
        cw[62-idx]   = cw_bit;
        sofv[62-idx] = cw_sof;
        eofv[62-idx] = cw_eof;
        idx++;
      end
      pstall = !rdy; pb = cw_bit; ps = cw_sof; pe = cw_eof;
      @(negedge clk);
      cyc++;
    end
    if (idx != 63) bad++;
    cw_ready = 1'b1;
  endtask

  initial begin
    logic [62:0]  cw, sofv, eofv;
    logic [125:0] seq, seq_exp;
    logic [23:0]  m5;
    logic         mr;
    int           bad, cyc, nvalid;

    rst_n = 1'b0; msg_data = '0; msg_valid = 1'b0; cw_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_msg_ready", 64'(msg_ready), 64'd1);
    chk("rst_cw_valid",  64'(cw_valid),  64'd0);
    chk("rst_cw_bit",    64'(cw_bit),    64'd0);
    chk("rst_sof",       64'(cw_sof),    64'd0);
    chk("rst_eof",       64'(cw_eof),    64'd0);
    chk("rst_busy",      64'(busy),      64'd0);

    // All-zero message: 63 zero bits, sof on first, eof on last
    frame(24'h000000, 1'b0, cw, sofv, eofv, bad, cyc);
    chk("zero_cw",   64'(cw),   64'd0);
    chk("zero_sof",  64'(sofv), 64'(SOF_EXP));
    chk("zero_eof",  64'(eofv), 64'(EOF_EXP));
    chk("zero_hs",   64'(bad),  64'd0);
    chk("zero_cyc",  64'(cyc),  64'd63);

    // Single low-order bit: parity equals g(x) without its top term
    frame(24'h000001, 1'b0, cw, sofv, eofv, bad, cyc);
    chk("one_cw",   64'(cw), 64'({24'h000001, 39'h769AC20921}));
    chk("one_sof",  64'(sofv), 64'(SOF_EXP));
    chk("one_eof",  64'(eofv), 64'(EOF_EXP));
    chk("one_hs",   64'(bad),  64'd0);
    chk("one_idle", 64'(cw_valid), 64'd0);

    // Back-to-back frames with msg_valid held
    msg_data = 24'hA5C3F0; msg_valid = 1'b1; cw_ready = 1'b1;
    @(negedge clk);
    nvalid = 0; seq = '0; mr = 1'b0;
    for (int i = 0; i < 126; i++) begin
      if (cw_valid === 1'b1) nvalid++;
      seq[125-i] = cw_bit;
      if (i == 62) begin
        msg_data = 24'h3C0F5A;
        #1;
        mr = msg_ready;
      end
      if (i == 63) msg_valid = 1'b0;
      @(negedge clk);
    end
    seq_exp = {exp_cw(24'hA5C3F0), exp_cw(24'h3C0F5A)};
    chk("b2b_ready_eof", 64'(mr),     64'd1);
    chk("b2b_nvalid",    64'(nvalid), 64'd126);
    chk("b2b_frame0",    64'(seq[125:63]), 64'(seq_exp[125:63]));
    chk("b2b_frame1",    64'(seq[62:0]),   64'(seq_exp[62:0]));
    chk("b2b_idle",      64'(cw_valid),    64'd0);

    // Random backpressure must not change the bit sequence
    frame(24'h5A5A5A, 1'b1, cw, sofv, eofv, bad, cyc);
    chk("stall_cw",  64'(cw),   64'(exp_cw(24'h5A5A5A)));
    chk("stall_sof", 64'(sofv), 64'(SOF_EXP));
    chk("stall_eof", 64'(eofv), 64'(EOF_EXP));
    chk("stall_hs",  64'(bad),  64'd0);

    // Reset while message bit 10 is on the line
    m5 = 24'h123456;
    msg_data = m5; msg_valid = 1'b1; cw_ready = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy",  64'(busy),      64'd1);
    chk("mid_ready", 64'(msg_ready), 64'd0);
    chk("mid_bit10", 64'(cw_bit),    64'(m5[13]));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(cw_valid),  64'd0);
    chk("abort_ready", 64'(msg_ready), 64'd1);
    chk("abort_busy",  64'(busy),      64'd0);
    chk("abort_bit",   64'(cw_bit),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    frame(24'hFEDCBA, 1'b0, cw, sofv, eofv, bad, cyc);
    chk("post_rst_cw",  64'(cw),  64'(exp_cw(24'hFEDCBA)));
    chk("post_rst_hs",  64'(bad), 64'd0);
    chk("post_rst_cyc", 64'(cyc), 64'd63);

`ifdef BCH_FRAME_CNT_EN
    chk("fcnt_one", 64'(frame_cnt), 64'd1);
    frame(24'h800000, 1'b0, cw, sofv, eofv, bad, cyc);
    chk("msb_cw", 64'(cw), 64'(exp_cw(24'h800000)));
    frame(24'hFFFFFF, 1'b1, cw, sofv, eofv, bad, cyc);
    chk("ones_cw", 64'(cw), 64'(exp_cw(24'hFFFFFF)));
    chk("fcnt_three", 64'(frame_cnt), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("fcnt_rst", 64'(frame_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
